// File: rtl/tone_arbiter_if.sv
// Bus between the tone sources, the tone arbiter and the tone generator.
// The master side drives requests and periods; the slave side (the arbiter) returns grant and tone.
interface tone_arbiter_if #(
  parameter int TONE_WIDTH = 24
);
  logic [1:0]            req;
  logic [TONE_WIDTH-1:0] tone0;
  logic [TONE_WIDTH-1:0] tone1;
  logic [1:0]            gnt;
  logic [TONE_WIDTH-1:0] tone_out;
  logic                  output_enable;

  modport master (
    output req, tone0, tone1,
    input  gnt, tone_out, output_enable
  );

  modport slave (
    input  req, tone0, tone1,
    output gnt, tone_out, output_enable
  );
endinterface

// File: rtl/tone_arbiter.sv
// Two-source tone arbiter: keyboard (0) has fixed priority over the music streamer (1), with a silent gap between grants.
// Optional macro TONE_ARB_PREEMPT_EN lets the keyboard take over once the streamer has held MIN_HOLD_CYCLES.
module tone_arbiter #(
  parameter int TONE_WIDTH      = 24,
  parameter int MIN_HOLD_CYCLES = 2500,
  parameter int GAP_CYCLES      = 250
) (
  input  logic          clk,
  input  logic          rst,
  tone_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int               GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam state_t           EXIT_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t                state;
  state_t                state_nxt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [1:0]            gnt_q;
  logic [1:0]            gnt_nxt;
  logic [TONE_WIDTH-1:0] tone_q;
  logic [TONE_WIDTH-1:0] tone_nxt;
  logic                  oe_q;
  logic                  rst_sync_n;

  // Reset asserts asynchronously but releases on a clock edge, so the first edge after
  // release only arms the core and arbitration starts on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_n <= 1'b0;
    else      rst_sync_n <= 1'b1;
  end

`ifdef TONE_ARB_PREEMPT_EN
  localparam int                HOLD_W   = (MIN_HOLD_CYCLES > 0) ? $clog2(MIN_HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  assign hold_done = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      hold_cnt <= '0;
    end else if ((state_nxt != state) || !((state == GRANT0) || (state == GRANT1))) begin
      hold_cnt <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req[0])      state_nxt = GRANT0;
        else if (bus.req[1]) state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!bus.req[0]) state_nxt = EXIT_STATE;
      end
      GRANT1: begin
        if (!bus.req[1]) state_nxt = EXIT_STATE;
`ifdef TONE_ARB_PREEMPT_EN
        else if (bus.req[0] && hold_done) state_nxt = EXIT_STATE;
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The period is only passed through once a grant is established and while it persists,
  // so the entry cycle and the exit cycle both present silence.
  always_comb begin
    gnt_nxt  = 2'b00;
    tone_nxt = '0;
    case (state_nxt)
      GRANT0: begin
        gnt_nxt = 2'b01;
        if (state == GRANT0) tone_nxt = bus.tone0;
      end
      GRANT1: begin
        gnt_nxt = 2'b10;
        if (state == GRANT1) tone_nxt = bus.tone1;
      end
      default: begin
        gnt_nxt  = 2'b00;
        tone_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      gap_cnt <= '0;
      gnt_q   <= 2'b00;
      tone_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      gap_cnt <= ((state == GAP) && (state_nxt == GAP)) ? gap_cnt + 1'b1 : '0;
      gnt_q   <= gnt_nxt;
      tone_q  <= tone_nxt;
      oe_q    <= |gnt_nxt;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.tone_out      = tone_q;
  assign bus.output_enable = oe_q;

  // Grants stay one-hot-or-zero and never hand over from one source to the other directly.
  always_ff @(posedge clk) begin
    if (rst_sync_n) begin
      assert (gnt_q != 2'b11);
      assert (oe_q == (gnt_q != 2'b00));
      assert (!(((gnt_q == 2'b01) && (gnt_nxt == 2'b10)) || ((gnt_q == 2'b10) && (gnt_nxt == 2'b01))));
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter: directed timing scenarios plus randomized traffic
// compared against an ownership/blocking reference model.
module tb_tone_arbiter;
  localparam int TW   = 24;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
`ifdef TONE_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_arbiter_if #(.TONE_WIDTH(TW)) bus ();

  tone_arbiter #(
    .TONE_WIDTH     (TW),
    .MIN_HOLD_CYCLES(HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [TW+2:0] obs;
  assign obs = {bus.gnt, bus.output_enable, bus.tone_out};

  // Reference model: who owns the output, how long they have held it, and how many
  // edges must still pass before a new owner may be chosen.
  int            owner;
  int            held;
  int            blocked;
  int            prev_owner;
  bit            drop;
  logic [1:0]    exp_gnt;
  logic [TW-1:0] exp_tone;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    = -1;
      held     = 0;
      blocked  = 1;
      exp_gnt  = 2'b00;
      exp_tone = '0;
    end else begin
      prev_owner = owner;
      if (owner >= 0) begin
        drop = !bus.req[owner] || (PREEMPT && owner == 1 && bus.req[0] && held >= HOLD);
        if (drop) begin
          owner   = -1;
          blocked = GAP;
        end else begin
          held = held + 1;
        end
      end else if (blocked > 0) begin
        blocked = blocked - 1;
      end else if (bus.req[0]) begin
        owner = 0;
        held  = 0;
      end else if (bus.req[1]) begin
        owner = 1;
        held  = 0;
      end
      exp_gnt  = (owner < 0) ? 2'b00 : 2'(1 << owner);
      exp_tone = (owner >= 0 && owner == prev_owner) ? ((owner == 0) ? bus.tone0 : bus.tone1) : '0;
    end
  end

  task automatic go_idle();
    @(negedge clk);
    bus.req = 2'b00;
    repeat (GAP + 3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 2'b11;
    bus.tone0 = 24'd5;
    bus.tone1 = 24'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_hold got=%h want=%h", obs, 27'h0); end
    @(negedge clk);
    bus.req = 2'b01;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL release_edge1 got=%h want=%h", obs, 27'h0); end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b01, 1'b1, 24'd0}) begin failures++; $display("FAIL release_edge2 got=%h want=%h", obs, {2'b01, 1'b1, 24'd0}); end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b01, 1'b1, 24'd5}) begin failures++; $display("FAIL release_tone got=%h want=%h", obs, {2'b01, 1'b1, 24'd5}); end
  endtask

  task automatic test_live_tone();
    go_idle();
    @(negedge clk);
    bus.req = 2'b10;
    bus.tone0 = 24'd0;
    bus.tone1 = 24'd1000;
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b10, 1'b1, 24'd0}) begin failures++; $display("FAIL grant1_latency got=%h want=%h", obs, {2'b10, 1'b1, 24'd0}); end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b10, 1'b1, 24'd1000}) begin failures++; $display("FAIL tone1_1000 got=%h want=%h", obs, {2'b10, 1'b1, 24'd1000}); end
    @(negedge clk);
    bus.tone1 = 24'd1200;
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b10, 1'b1, 24'd1200}) begin failures++; $display("FAIL tone1_1200 got=%h want=%h", obs, {2'b10, 1'b1, 24'd1200}); end
  endtask

  task automatic test_priority();
    logic [TW-1:0] t;
    go_idle();
    @(negedge clk);
    bus.req = 2'b11;
    bus.tone0 = 24'd777;
    bus.tone1 = 24'd555;
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b01, 1'b1, 24'd0}) begin failures++; $display("FAIL priority_grant got=%h want=%h", obs, {2'b01, 1'b1, 24'd0}); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t = TW'($urandom);
      bus.tone0 = t;
      bus.tone1 = ~t;
      @(posedge clk); #1;
      checks++;
      if (obs !== {2'b01, 1'b1, t}) begin failures++; $display("FAIL priority_follow got=%h want=%h", obs, {2'b01, 1'b1, t}); end
    end
  endtask

  task automatic test_gap_timing();
    logic [TW+2:0] want;
    @(negedge clk);
    bus.req = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      want = (k == 6) ? {2'b10, 1'b1, 24'd0} : '0;
      checks++;
      if (obs !== want) begin failures++; $display("FAIL gap_timing k=%0d got=%h want=%h", k, obs, want); end
    end
  endtask

  task automatic test_preempt();
    logic [TW+2:0] want;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req = 2'b11;
    bus.tone0 = 24'd300;
    bus.tone1 = 24'd400;
    for (int j = 3; j <= 20; j++) begin
      @(posedge clk); #1;
`ifdef TONE_ARB_PREEMPT_EN
      if (j <= HOLD)                want = {2'b10, 1'b1, 24'd400};
      else if (j < HOLD + GAP + 2)  want = '0;
      else if (j == HOLD + GAP + 2) want = {2'b01, 1'b1, 24'd0};
      else                          want = {2'b01, 1'b1, 24'd300};
`else
      want = {2'b10, 1'b1, 24'd400};
`endif
      checks++;
      if (obs !== want) begin failures++; $display("FAIL preempt j=%0d got=%h want=%h", j, obs, want); end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    @(negedge clk);
    bus.req = 2'b10;
    bus.tone1 = 24'd1234;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'b10, 1'b1, 24'd1234}) begin failures++; $display("FAIL pre_reset_grant1 got=%h want=%h", obs, {2'b10, 1'b1, 24'd1234}); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL async_reset_grant got=%h want=%h", obs, 27'h0); end
    @(negedge clk);
    bus.req = 2'b01;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL post_reset1_edge1 got=%h want=%h", obs, 27'h0); end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b01, 1'b1, 24'd0}) begin failures++; $display("FAIL post_reset1_edge2 got=%h want=%h", obs, {2'b01, 1'b1, 24'd0}); end
    @(negedge clk);
    bus.req = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req = 2'b10;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL async_reset_gap got=%h want=%h", obs, 27'h0); end
    @(negedge clk);
    bus.req = 2'b01;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL post_reset2_edge1 got=%h want=%h", obs, 27'h0); end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b01, 1'b1, 24'd0}) begin failures++; $display("FAIL post_reset2_edge2 got=%h want=%h", obs, {2'b01, 1'b1, 24'd0}); end
  endtask

  task automatic test_random();
    int            rst_hold;
    int            b;
    logic [TW+2:0] want;
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, 1);
        bus.req[b] = ~bus.req[b];
      end
      if ($urandom_range(0, 3) == 0) bus.tone0 = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom);
      if ($urandom_range(0, 3) == 0) bus.tone1 = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) #2 rst = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_hold = $urandom_range(1, 3);
        #2 rst = 1'b0;
        #1;
        want = {exp_gnt, |exp_gnt, exp_tone};
        checks++;
        if (obs !== want) begin failures++; $display("FAIL random_async_reset cycle=%0d got=%h want=%h", i, obs, want); end
      end
      @(posedge clk); #1;
      want = {exp_gnt, |exp_gnt, exp_tone};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL random cycle=%0d req=%b got=%h want=%h", i, bus.req, obs, want); end
    end
  endtask

  initial begin
    bus.req   = 2'b00;
    bus.tone0 = '0;
    bus.tone1 = '0;
    test_reset();
    test_live_tone();
    test_priority();
    test_gap_timing();
    test_preempt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
